// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the register bank: five channels, 32-bit address and data.
interface axi_lite_slave_regs_if;
    // Write address channel
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    // Write data channel
    logic        wvalid;
    logic [31:0] wdata;
    logic        wready;
    // Write response channel
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    // Read address channel
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    // Read data channel
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit read/write registers,
// independent AW/W acceptance, one-cycle read capture, flat register export.
module axi_lite_slave_regs #(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    axi_lite_slave_regs_if.slave   bus,
    output logic [NUM_REGS*32-1:0] regs_out
);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [31:0] regs [NUM_REGS];

    // Write path state
    logic        aw_held;
    logic        w_held;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    // Read path state
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // Handshake and commit strobes
    logic awready_i;
    logic wready_i;
    logic arready_i;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic commit_ok;

    // Word aligned and inside the register window
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return a[2 +: IDX_W];
    endfunction

    // Readies depend only on internal state, never on the valid inputs
    always_comb begin
        awready_i = !aw_held && !bvalid_q;
        wready_i  = !w_held  && !bvalid_q;
        arready_i = !rvalid_q;
        aw_hs     = bus.awvalid && awready_i;
        w_hs      = bus.wvalid  && wready_i;
        ar_hs     = bus.arvalid && arready_i;
        commit    = aw_held && w_held;
        commit_ok = commit && addr_ok(awaddr_q);
    end

    assign bus.awready = awready_i;
    assign bus.wready  = wready_i;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_i;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // Latch write address and data independently, then commit once both are held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= bus.awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= bus.wdata;
            end
            // Both readies are low while both flags are set, so commit never races a new handshake
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= addr_ok(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && bus.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register array: updated only on a commit to a valid address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_ok) begin
            regs[addr_idx(awaddr_q)] <= wdata_q;
        end
    end

    // Capture read data at the AR handshake; a same-edge write is seen only by later reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            if (addr_ok(bus.araddr)) begin
                rdata_q <= regs[addr_idx(bus.araddr)];
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end else if (rvalid_q && bus.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // Flat export of all registers, register i at bits [32*i +: 32]
    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_out[32*i +: 32] = regs[i];
        end
    end
endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite slave register bank that sits directly downstream of the AXI4-Lite master, terminating its five channels. It holds NUM_REGS 32-bit read/write registers, accepts write address and write data independently, and issues a write response. It answers reads with one-cycle data capture. All register contents are exported as a flat bus for fabric logic.

## Interface
Parameters:
- NUM_REGS, 8, number of 32-bit registers (power of two, 2..64)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- awvalid  input  1  write address valid
- awaddr  input  32  write byte address
- awready  output  1  slave can accept write address
- wvalid  input  1  write data valid
- wdata  input  32  write data
- wready  output  1  slave can accept write data
- bvalid  output  1  write response valid
- bresp  output  2  2'b00 OKAY, 2'b10 SLVERR (may be left unconnected)
- bready  input  1  master accepts response
- arvalid  input  1  read address valid
- araddr  input  32  read byte address
- arready  output  1  slave can accept read address
- rvalid  output  1  read data valid
- rdata  output  32  read data
- rresp  output  2  2'b00 OKAY, 2'b10 SLVERR (may be left unconnected)
- rready  input  1  master accepts read data
- regs_out  output  NUM_REGS*32  register i at bits [32*i+31 : 32*i]

## Operation
- Address decode:
  - index = addr[2 +: log2(NUM_REGS)].
  - Address valid iff addr[1:0]==0 and addr[31:2] < NUM_REGS.
  - All other addresses are invalid: misaligned, or above range.
- Write path, with flags aw_held and w_held and a bvalid register:
  - awready = !aw_held && !bvalid. On AW handshake, latch awaddr and set aw_held.
  - wready = !w_held && !bvalid. On W handshake, latch wdata and set w_held.
  - AW and W may arrive in either order or in the same cycle.
  - When aw_held && w_held, on the next edge:
    - if the address is valid, write the register and set bresp=OKAY;
    - otherwise drop the write and set bresp=SLVERR;
    - set bvalid and clear both held flags.
  - bvalid, bresp hold until bready. The handshake clears bvalid.
  - No new AW/W is accepted while bvalid=1.
- Read path, with a rvalid register:
  - arready = !rvalid.
  - On AR handshake, at that edge:
    - capture rdata = register[index] and rresp=OKAY if the address is valid;
    - otherwise capture rdata=0 and rresp=SLVERR;
    - set rvalid.
  - rvalid, rdata, rresp hold stable until rready. The handshake clears rvalid.
- Read and write paths are fully independent and may be active concurrently.
- Read/write collision:
  - A read capture and a register write to the same register at the same edge returns the OLD value.
  - The new value is visible to any read captured on a later edge.
- regs_out reflects register state directly, updated at the write commit edge.

## Timing
- Reset, asynchronous, any time including mid-transaction:
  - all registers = 0;
  - aw_held = w_held = 0;
  - bvalid = rvalid = 0;
  - bresp = rresp = 2'b00, rdata = 0;
  - awready = wready = arready = 1 combinationally from the cleared state.
  - The in-flight transaction is discarded.
- Write latency:
  - last of the AW/W handshakes at edge E → commit and bvalid=1 at edge E+1;
  - with bready already high, bvalid drops at edge E+2.
- Read latency:
  - AR handshake at edge E → rvalid=1 with data after E;
  - with rready high, rvalid drops at edge E+1.
- Back-to-back reads: with rready held high, one read completes every 2 cycles. arready is low while rvalid=1.
- Ready outputs are combinational functions of internal state only, never of the *valid inputs.
- Input stability: a valid input dropped before its handshake has no effect.

## Test plan
- Reset, then write 0xA5A5_0001 to addr 0x04 with AW one cycle before W:
  - awready/wready each drop after their handshake;
  - bvalid=1, bresp=00 exactly one cycle after the W handshake;
  - regs_out[63:32]=0xA5A5_0001.
- Write addr 0x1C (data 0x1234_5678) with AW and W in the same cycle, bready held low for 3 cycles:
  - bvalid stays high and awready/wready stay low until bready;
  - then read 0x1C returns rdata=0x1234_5678, rresp=00.
- Write 0x20 and write 0x06, each with data 0xFFFF_FFFF:
  - both get bresp=10 and leave all registers unchanged.
  - Read 0x20 → rdata=0, rresp=10.
- Read addr 0x08 while a write of 0xCAFE_0000 to 0x08 commits at the same edge:
  - the read returns the old value 0;
  - a following read returns 0xCAFE_0000.
- Assert rstn low while aw_held=1 and rvalid=1 (rready low):
  - all outputs return to reset values asynchronously;
  - after release, a fresh write/read to 0x00 completes normally.
- Issue four reads with rready tied high:
  - the interval between successive rvalid pulses is 2 cycles;
  - arready is never high while rvalid=1.
